// File: rtl/w_ram_row_buffer_if.sv
// ---------------------------------------------------------------------------
// w_ram_row_buffer_if
// Bundles the element-write port, the clear pulse, the row-stream request
// handshake and the row output of the weight row buffer.
// Optional build macro: W_RAM_SKEW_EN adds the per-lane valid vector
// row_lane_valid used by the diagonally skewed output.
// ---------------------------------------------------------------------------
interface w_ram_row_buffer_if #(
    parameter int INTEGER_BIT      = 7,
    parameter int W_RAM_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH       = 8,
    parameter int ARRAY_SIZE       = 8
);
    // Element write side (from the weight address generator / BRAM)
    logic                               w_ram_write_req;
    logic [W_RAM_ADDR_WIDTH-1:0]        w_ram_write_addr;
    logic [INTEGER_BIT-1:0]             w_ram_index_addr;
    logic [DATA_WIDTH-1:0]              w_ram_write_data;
    logic                               clear;

    // Row stream request
    logic                               read_enable;
    logic [W_RAM_ADDR_WIDTH-1:0]        read_start_addr;
    logic [INTEGER_BIT-1:0]             read_count;

    // Row stream output towards the systolic array
    logic [ARRAY_SIZE*DATA_WIDTH-1:0]   row_data;
    logic                               row_valid;
    logic                               finish;
`ifdef W_RAM_SKEW_EN
    logic [ARRAY_SIZE-1:0]              row_lane_valid;
`endif

    // Requester side: drives writes and stream requests, receives rows
    modport master (
        output w_ram_write_req,
        output w_ram_write_addr,
        output w_ram_index_addr,
        output w_ram_write_data,
        output clear,
        output read_enable,
        output read_start_addr,
        output read_count,
        input  row_data,
        input  row_valid,
        input  finish
`ifdef W_RAM_SKEW_EN
        ,
        input  row_lane_valid
`endif
    );

    // Row buffer side
    modport slave (
        input  w_ram_write_req,
        input  w_ram_write_addr,
        input  w_ram_index_addr,
        input  w_ram_write_data,
        input  clear,
        input  read_enable,
        input  read_start_addr,
        input  read_count,
        output row_data,
        output row_valid,
        output finish
`ifdef W_RAM_SKEW_EN
        ,
        output row_lane_valid
`endif
    );
endinterface

// File: rtl/w_ram_row_buffer.sv
// ---------------------------------------------------------------------------
// w_ram_row_buffer
// Weight RAM placed after the weight address generator. Single-element
// writes (row, lane, data) are assembled into full array-width rows; each
// lane carries a valid bit so lanes never written read back as zero, which
// gives zero padding for matrices smaller than the array. Rows are later
// streamed to the systolic array under a read_enable / finish handshake.
//
// Optional build macro: W_RAM_SKEW_EN
//   Output lane i is delayed by i extra cycles (diagonal skew), DRAIN is
//   stretched to ARRAY_SIZE cycles so finish follows the last lane, and a
//   per-lane valid vector row_lane_valid is driven.
// ---------------------------------------------------------------------------
module w_ram_row_buffer #(
    parameter int INTEGER_BIT      = 7,
    parameter int W_RAM_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH       = 8,
    parameter int ARRAY_SIZE       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    w_ram_row_buffer_if.slave bus
);

    localparam int DEPTH   = 1 << W_RAM_ADDR_WIDTH;
    localparam int ROW_W   = ARRAY_SIZE * DATA_WIDTH;
    localparam int LANE_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int DRAIN_W = LANE_W + 1;
`ifdef W_RAM_SKEW_EN
    // The last lane trails lane 0 by ARRAY_SIZE-1 cycles
    localparam int DRAIN_LEN = ARRAY_SIZE;
`else
    localparam int DRAIN_LEN = 1;
`endif
    localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);
    localparam logic [INTEGER_BIT-1:0] IDX_LIMIT  = INTEGER_BIT'(ARRAY_SIZE);
    localparam logic [INTEGER_BIT-1:0] CNT_ONE    = INTEGER_BIT'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Zero every lane whose valid bit is clear
    function automatic logic [ROW_W-1:0] mask_row(
        input logic [ROW_W-1:0]      row,
        input logic [ARRAY_SIZE-1:0] vld
    );
        logic [ROW_W-1:0] res;
        res = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (vld[i]) begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = row[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                res[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
        return res;
    endfunction

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic                       wr_ok_s;
    logic [LANE_W-1:0]          wr_lane_s;
    logic                       latch_s;
    logic                       issue_s;
    logic                       finish_nxt_s;
    logic [W_RAM_ADDR_WIDTH-1:0] rd_addr_r;
    logic [INTEGER_BIT-1:0]     rd_left_r;
    logic [DRAIN_W-1:0]         drain_cnt_r;
    logic [ROW_W-1:0]           mem_r [DEPTH];
    logic [ARRAY_SIZE-1:0]      lane_vld_r [DEPTH];
    logic [ROW_W-1:0]           base_data_r;
    logic                       base_valid_r;
    logic                       finish_r;

    // Decode the element write: out-of-range lanes are dropped entirely
    always_comb begin
        wr_ok_s   = bus.w_ram_write_req && (bus.w_ram_index_addr < IDX_LIMIT);
        wr_lane_s = bus.w_ram_index_addr[LANE_W-1:0];
    end

    // Element storage: lane write into the addressed row, contents not reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[bus.w_ram_write_addr][wr_lane_s*DATA_WIDTH +: DATA_WIDTH] <= bus.w_ram_write_data;
        end
    end

    // Lane-valid bits: clear wipes everything, a same-edge write still sets its lane
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < DEPTH; r++) begin
                lane_vld_r[r] <= '0;
            end
        end else begin
            if (bus.clear) begin
                for (int r = 0; r < DEPTH; r++) begin
                    lane_vld_r[r] <= '0;
                end
            end
            if (wr_ok_s) begin
                lane_vld_r[bus.w_ram_write_addr][wr_lane_s] <= 1'b1;
            end
        end
    end

    // Stream FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stream FSM next-state logic; dropping read_enable mid-stream aborts to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.read_enable) begin
                    state_nxt_s = (bus.read_count == '0) ? ST_DONE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!bus.read_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (rd_left_r == CNT_ONE) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!bus.read_enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (bus.read_enable) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Stream FSM outputs: latch request, issue a RAM read, next finish level
    always_comb begin
        latch_s = 1'b0;
        issue_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                latch_s = bus.read_enable;
            end
            ST_READ: begin
                issue_s = bus.read_enable;
            end
            ST_DRAIN: begin
                issue_s = 1'b0;
            end
            ST_DONE: begin
                latch_s = 1'b0;
            end
            default: begin
                latch_s = 1'b0;
                issue_s = 1'b0;
            end
        endcase
        finish_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Read pointer, remaining-row count and drain counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_r   <= '0;
            rd_left_r   <= '0;
            drain_cnt_r <= '0;
        end else begin
            if (latch_s) begin
                rd_addr_r <= bus.read_start_addr;
                rd_left_r <= bus.read_count;
            end else if (issue_s) begin
                // Address wraps naturally modulo the RAM depth
                rd_addr_r <= rd_addr_r + W_RAM_ADDR_WIDTH'(1);
                rd_left_r <= rd_left_r - CNT_ONE;
            end
            if ((state_r == ST_DRAIN) && bus.read_enable) begin
                drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
            end else begin
                drain_cnt_r <= '0;
            end
        end
    end

    // Synchronous read-first RAM port with lane masking; data is zero when not valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_data_r  <= '0;
            base_valid_r <= 1'b0;
        end else begin
            base_valid_r <= issue_s;
            if (issue_s) begin
                base_data_r <= mask_row(mem_r[rd_addr_r], lane_vld_r[rd_addr_r]);
            end else begin
                base_data_r <= '0;
            end
        end
    end

    // finish register: high for every cycle spent in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            finish_r <= 1'b0;
        end else begin
            finish_r <= finish_nxt_s;
        end
    end

`ifdef W_RAM_SKEW_EN
    logic [ROW_W-1:0]      skew_data_s;
    logic [ARRAY_SIZE-1:0] skew_vld_s;
    logic                  flush_s;

    // An aborted stream must not leave trailing lanes in the skew lines
    assign flush_s = ((state_r == ST_READ) || (state_r == ST_DRAIN)) && !bus.read_enable;

    // Lane 0 is not delayed
    assign skew_data_s[DATA_WIDTH-1:0] = base_data_r[DATA_WIDTH-1:0];
    assign skew_vld_s[0]               = base_valid_r;

    for (genvar g = 1; g < ARRAY_SIZE; g++) begin : g_lane_skew
        logic [DATA_WIDTH-1:0] d_sr_r [g];
        logic [g-1:0]          v_sr_r;

        // Delay line of g stages for lane g data and valid
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k < g; k++) begin
                    d_sr_r[k] <= '0;
                end
                v_sr_r <= '0;
            end else if (flush_s) begin
                for (int k = 0; k < g; k++) begin
                    d_sr_r[k] <= '0;
                end
                v_sr_r <= '0;
            end else begin
                d_sr_r[0] <= base_data_r[g*DATA_WIDTH +: DATA_WIDTH];
                v_sr_r[0] <= base_valid_r;
                for (int k = 1; k < g; k++) begin
                    d_sr_r[k] <= d_sr_r[k-1];
                    v_sr_r[k] <= v_sr_r[k-1];
                end
            end
        end

        assign skew_data_s[g*DATA_WIDTH +: DATA_WIDTH] = d_sr_r[g-1];
        assign skew_vld_s[g]                           = v_sr_r[g-1];
    end

    assign bus.row_data       = skew_data_s;
    assign bus.row_valid      = base_valid_r;
    assign bus.row_lane_valid = skew_vld_s;
`else
    assign bus.row_data  = base_data_r;
    assign bus.row_valid = base_valid_r;
`endif
    assign bus.finish = finish_r;

endmodule

// File: tb/tb_w_ram_row_buffer.sv
// ---------------------------------------------------------------------------
// tb_w_ram_row_buffer
// Directed bench for w_ram_row_buffer (ARRAY_SIZE=4, 7-bit row address).
// A bench-side RAM model predicts each streamed row; expected rows and their
// arrival cycles are queued when a stream is requested and checked by a
// monitor whenever row_valid is seen.
// ---------------------------------------------------------------------------
module tb_w_ram_row_buffer;

    localparam int IB    = 7;
    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int AS    = 4;
    localparam int RW    = AS * DW;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    w_ram_row_buffer_if #(.INTEGER_BIT(IB), .W_RAM_ADDR_WIDTH(AW),
                          .DATA_WIDTH(DW), .ARRAY_SIZE(AS)) bus ();

    w_ram_row_buffer #(.INTEGER_BIT(IB), .W_RAM_ADDR_WIDTH(AW),
                       .DATA_WIDTH(DW), .ARRAY_SIZE(AS)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [RW-1:0] data;
        int            cyc;
    } exp_t;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            c0    = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] m_data [DEPTH][AS];
    bit            m_vld  [DEPTH][AS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [RW-1:0] exp_row(input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int i = 0; i < AS; i++) begin
            if (m_vld[r][i]) v[i*DW +: DW] = m_data[r][i];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++)
            for (int i = 0; i < AS; i++) m_vld[r][i] = 1'b0;
    endtask

    // One-cycle write and/or clear, then update the model
    task automatic wr(input bit req, input int row, input int idx, input logic [7:0] d, input bit clr);
        bus.w_ram_write_req  = req;
        bus.w_ram_write_addr = AW'(row);
        bus.w_ram_index_addr = IB'(idx);
        bus.w_ram_write_data = d;
        bus.clear            = clr;
        tick();
        bus.w_ram_write_req  = 1'b0;
        bus.clear            = 1'b0;
        if (clr) model_clear();
        if (req && idx < AS) begin
            m_data[row][idx] = d;
            m_vld[row][idx]  = 1'b1;
        end
    endtask

    task automatic start_stream(input int start, input int count);
        exp_t e;
        c0 = cyc;
        for (int k = 0; k < count; k++) begin
            e.data = exp_row((start + k) % DEPTH);
            e.cyc  = c0 + 2 + k;
            exp_q.push_back(e);
        end
        bus.read_start_addr = AW'(start);
        bus.read_count      = IB'(count);
        bus.read_enable     = 1'b1;
    endtask

    task automatic finish_stream(input int count, input string tag);
        int fcyc;
        int exp_f;
        fcyc  = -1;
        exp_f = (count == 0) ? c0 + 1 : c0 + count + 2;
        for (int t = 0; t < count + 40 && fcyc < 0; t++) begin
            @(negedge clk);
            if (bus.finish === 1'b1) fcyc = cyc;
        end
        check({tag, "_finish_cycle"}, 64'(fcyc), 64'(exp_f));
        @(negedge clk);
        check({tag, "_finish_held"}, 64'(bus.finish), 64'h1);
        @(posedge clk);
        #1;
        bus.read_enable = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_finish_release"}, 64'(bus.finish), 64'h0);
        check({tag, "_rows_delivered"}, 64'(exp_q.size()), 64'h0);
        tick();
    endtask

    task automatic stream(input int start, input int count, input string tag);
        start_stream(start, count);
        finish_stream(count, tag);
    endtask

    // Scoreboard monitor: every valid row must match the next queued row and cycle
    always @(negedge clk) begin : mon
        exp_t e;
        if (rstn === 1'b1) begin
            if (bus.row_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL row_unexpected observed=0x%0h expected=no_row", bus.row_data);
                end else begin
                    e = exp_q.pop_front();
                    check("row_data", 64'(bus.row_data), 64'(e.data));
                    check("row_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("idle_data_zero", 64'(bus.row_data), 64'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.w_ram_write_req  = 1'b0;
        bus.w_ram_write_addr = '0;
        bus.w_ram_index_addr = '0;
        bus.w_ram_write_data = '0;
        bus.clear            = 1'b0;
        bus.read_enable      = 1'b0;
        bus.read_start_addr  = '0;
        bus.read_count       = '0;
        model_clear();

        // Reset values
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check("rst_row_valid", 64'(bus.row_valid), 64'h0);
        check("rst_row_data",  64'(bus.row_data),  64'h0);
        check("rst_finish",    64'(bus.finish),    64'h0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        // Element fill: rows 0..1, lanes 0..3 = 0x10+4r+i
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < AS; i++)
                wr(1'b1, r, i, 8'(8'h10 + 4 * r + i), 1'b0);
        stream(0, 2, "fill");

        // Zero padding: only lanes 0,1 of row 5 after a clear
        wr(1'b0, 0, 0, 8'h00, 1'b1);
        wr(1'b1, 5, 0, 8'hAA, 1'b0);
        wr(1'b1, 5, 1, 8'hBB, 1'b0);
        stream(5, 1, "pad");

        // Clear colliding with a write, then out-of-range indices ignored
        wr(1'b1, 6, 2, 8'h66, 1'b0);
        wr(1'b1, 3, 2, 8'h55, 1'b1);
        wr(1'b1, 3, 4, 8'h77, 1'b0);
        wr(1'b1, 3, 9, 8'h78, 1'b0);
        stream(0, 8, "clr_oob");

        // Address wrap 127 -> 0 -> 1
        wr(1'b1, 127, 3, 8'hC7, 1'b0);
        wr(1'b1, 0,   0, 8'hD0, 1'b0);
        wr(1'b1, 1,   1, 8'hD1, 1'b0);
        stream(127, 3, "wrap");

        // Zero count: no rows, finish one cycle after the request
        stream(10, 0, "zero");

        // Read-first: the read of row 2 and a write to row 2 lane 0 share an edge
        wr(1'b1, 2, 0, 8'h42, 1'b0);
        start_stream(2, 1);
        tick();
        wr(1'b1, 2, 0, 8'h99, 1'b0);
        finish_stream(1, "rf_old");
        stream(2, 1, "rf_new");

        // Abort after the first row of a 4-row stream
        start_stream(0, 4);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        tick();
        bus.read_enable = 1'b0;
        @(negedge clk);
        check("abort_first_valid", 64'(bus.row_valid), 64'h1);
        @(negedge clk);
        check("abort_valid_low", 64'(bus.row_valid), 64'h0);
        check("abort_finish_low", 64'(bus.finish), 64'h0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("abort_no_finish", 64'(bus.finish), 64'h0);
        end
        tick();
        stream(1, 2, "after_abort");

        // Asynchronous reset in the middle of a stream
        start_stream(0, 4);
        tick();
        tick();
        @(negedge clk);
        check("pre_reset_valid", 64'(bus.row_valid), 64'h1);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_row_valid", 64'(bus.row_valid), 64'h0);
        check("mid_rst_row_data",  64'(bus.row_data),  64'h0);
        check("mid_rst_finish",    64'(bus.finish),    64'h0);
        exp_q.delete();
        bus.read_enable = 1'b0;
        model_clear();
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        wr(1'b1, 4, 3, 8'hE4, 1'b0);
        wr(1'b1, 5, 0, 8'hE5, 1'b0);
        stream(4, 2, "post_rst");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
